// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult_if
// Description : Request/response bundle for the sequential Booth multiplier.
//               The master issues operands with a start request. The slave
//               reports busy/done and the registered product.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_seq_mult_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult
// Description : Iterative radix-2 Booth multiplier. Operands are extended to
//               WIDTH+1 bits (sign- or zero-extension) so one datapath serves
//               signed and unsigned modes. One add/sub-and-shift per clock,
//               WIDTH+1 iterations, registered 2*WIDTH-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input wire              clk,
    input wire              rst_n,
    booth_seq_mult_if.slave bus
);
    localparam int c_N  = WIDTH + 1;
    localparam int c_CW = $clog2(c_N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;

    logic [c_N-1:0]       r_ac;
    logic [c_N-1:0]       r_qr;
    logic [c_N-1:0]       r_br;
    logic                 r_q1;
    logic [c_CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [c_N-1:0]       w_ext_m;
    logic [c_N-1:0]       w_ext_q;
    logic [c_N-1:0]       w_sum;
    logic [c_N-1:0]       w_ac_sh;
    logic [c_N-1:0]       w_qr_sh;

    // Extension bit is the operand MSB in signed mode, zero otherwise. The
    // extra bit keeps BR away from the most negative N-bit value, so AC
    // never overflows.
    assign w_ext_m = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
    assign w_ext_q = {bus.signed_mode & bus.multiplier[WIDTH-1],   bus.multiplier};

    // Booth recoding of {QR[0], q_1}: 10 subtracts, 01 adds, else hold.
    always_comb begin
        w_sum = r_ac;
        case ({r_qr[0], r_q1})
            2'b10:   w_sum = r_ac - r_br;
            2'b01:   w_sum = r_ac + r_br;
            default: w_sum = r_ac;
        endcase
    end

    // Arithmetic right shift of {AC, QR, q_1}; q_1 picks up QR[0] below.
    assign w_ac_sh = {w_sum[c_N-1], w_sum[c_N-1:1]};
    assign w_qr_sh = {w_sum[0], r_qr[c_N-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; start is only honoured out of RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == c_CW'(c_N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration, and product latch on the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac      <= '0;
            r_qr      <= '0;
            r_br      <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_ac  <= '0;
            r_qr  <= w_ext_q;
            r_br  <= w_ext_m;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_ac  <= w_ac_sh;
            r_qr  <= w_qr_sh;
            r_q1  <= r_qr[0];
            r_cnt <= r_cnt + c_CW'(1);
            if (w_last) begin
                // The 2N-bit result's top two bits are pure sign extension.
                r_product <= {w_ac_sh[WIDTH-2:0], w_qr_sh};
            end
        end
    end

    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.product = r_product;
endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_mult
// Description : Self-checking bench for booth_seq_mult at WIDTH 8, 2, 4, 16.
//               Expected products go into a scoreboard queue as requests are
//               issued and are popped when done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_mult;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    booth_seq_mult_if #(.WIDTH(8))  if8  ();
    booth_seq_mult_if #(.WIDTH(2))  if2  ();
    booth_seq_mult_if #(.WIDTH(4))  if4  ();
    booth_seq_mult_if #(.WIDTH(16)) if16 ();

    booth_seq_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    booth_seq_mult #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    booth_seq_mult #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    booth_seq_mult #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic sm,
                                            input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        longint p;
        longint mask;
        mask = (longint'(1) << w) - 1;
        a = longint'(m) & mask;
        b = longint'(q) & mask;
        if (sm && a[w-1]) a = a - (longint'(1) << w);
        if (sm && b[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input logic st, input logic sm,
                          input logic [31:0] m, input logic [31:0] q);
        case (w)
            2:  begin if2.start  = st; if2.signed_mode  = sm; if2.multiplicand  = m[1:0];  if2.multiplier  = q[1:0];  end
            4:  begin if4.start  = st; if4.signed_mode  = sm; if4.multiplicand  = m[3:0];  if4.multiplier  = q[3:0];  end
            16: begin if16.start = st; if16.signed_mode = sm; if16.multiplicand = m[15:0]; if16.multiplier = q[15:0]; end
            default: begin if8.start = st; if8.signed_mode = sm; if8.multiplicand = m[7:0]; if8.multiplier = q[7:0]; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            2:       return if2.done;
            4:       return if4.done;
            16:      return if16.done;
            default: return if8.done;
        endcase
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        case (w)
            2:       return {28'd0, if2.product};
            4:       return {24'd0, if4.product};
            16:      return if16.product;
            default: return {16'd0, if8.product};
        endcase
    endfunction

    // Drive a WIDTH=8 request through its sampling edge, optionally booking
    // the expected product.
    task automatic start8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                          input logic [31:0] exp, input bit push);
        set_in(8, 1'b1, sm, {24'd0, m}, {24'd0, q});
        if (push) sb_q.push_back(exp);
        tick();
        if8.start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen (bounded).
    task automatic wait_done8(input int c0, output int cyc);
        cyc = c0;
        while (if8.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(8, 0, 0, 0, 0); set_in(2, 0, 0, 0, 0);
        set_in(4, 0, 0, 0, 0); set_in(16, 0, 0, 0, 0);
        repeat (3) tick();
        n_checks++; if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if8.busy); end
        n_checks++; if (if8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", if8.done); end
        n_checks++; if (if8.product !== 16'h0) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", if8.product); end
        n_checks++; if (if16.product !== 32'h0) begin n_fail++; $display("FAIL reset_product16: got %h expected 0", if16.product); end
        #4 rst_n = 1'b1;
        tick();
        n_checks++; if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", if8.busy); end
    endtask

    task automatic test_signed_corner();
        logic [31:0] exp;
        int cyc;
        start8(1'b1, 8'h80, 8'h80, 32'h4000, 1'b1);
        n_checks++; if (if8.busy !== 1'b1) begin n_fail++; $display("FAIL corner_busy: got %b expected 1", if8.busy); end
        wait_done8(0, cyc);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL corner_latency: got %0d expected 9", cyc); end
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL corner_product: got %h expected %h", get_prod(8), exp); end
        tick();
        n_checks++; if (if8.done !== 1'b0) begin n_fail++; $display("FAIL corner_done_width: got %b expected 0", if8.done); end
    endtask

    task automatic test_mixed_signs();
        logic [31:0] exp;
        int cyc;
        start8(1'b1, 8'hF9, 8'h05, 32'hFFDD, 1'b1);
        repeat (3) tick();
        n_checks++; if (if8.product !== 16'h4000) begin n_fail++; $display("FAIL product_hold_run: got %h expected 4000", if8.product); end
        wait_done8(3, cyc);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL mixed_latency: got %0d expected 9", cyc); end
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL mixed_product: got %h expected %h", get_prod(8), exp); end
        repeat (2) tick();
        n_checks++; if (if8.product !== 16'hFFDD) begin n_fail++; $display("FAIL product_hold_idle: got %h expected ffdd", if8.product); end
    endtask

    task automatic test_unsigned_max();
        logic [31:0] exp;
        int cyc;
        start8(1'b0, 8'hFF, 8'hFF, 32'hFE01, 1'b1);
        wait_done8(0, cyc);
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL unsigned_max: got %h expected %h", get_prod(8), exp); end
        start8(1'b1, 8'hFF, 8'hFF, 32'h0001, 1'b1);
        wait_done8(0, cyc);
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL signed_minus1_sq: got %h expected %h", get_prod(8), exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int cyc;
        int extra_done;
        start8(1'b0, 8'd3, 8'd4, 32'h000C, 1'b1);
        tick();
        // Ignored re-requests while busy, also flipping the mode.
        set_in(8, 1'b1, 1'b1, 32'd9, 32'd9);
        repeat (4) tick();
        set_in(8, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_done8(5, cyc);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 9", cyc); end
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL b2b_first_product: got %h expected %h", get_prod(8), exp); end
        // Start in the DONE cycle is accepted at the next edge.
        start8(1'b0, 8'd6, 8'd7, 32'h002A, 1'b1);
        n_checks++; if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", if8.busy, if8.done); end
        wait_done8(0, cyc);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 9", cyc); end
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL b2b_second_product: got %h expected %h", get_prod(8), exp); end
        extra_done = 0;
        repeat (12) begin
            tick();
            if (if8.done === 1'b1 || if8.busy === 1'b1) extra_done++;
        end
        n_checks++; if (extra_done !== 0) begin n_fail++; $display("FAIL b2b_no_extra_op: got %0d active cycles expected 0", extra_done); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] exp;
        int cyc;
        int seen;
        start8(1'b0, 8'd100, 8'd100, 32'd0, 1'b0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.product !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid_run: got busy=%b done=%b product=%h expected 0/0/0000", if8.busy, if8.done, if8.product);
        end
        tick();
        #4 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (if8.done === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d done cycles expected 0", seen); end
        start8(1'b0, 8'd2, 8'd3, 32'h0006, 1'b1);
        wait_done8(0, cyc);
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(8) !== exp) begin n_fail++; $display("FAIL reset_recover: got %h expected %h", get_prod(8), exp); end
        tick();
    endtask

    // One request at width w, checked for latency and product.
    task automatic sweep_op(input int w, input logic sm, input logic [31:0] m, input logic [31:0] q);
        logic [31:0] exp;
        int cyc;
        set_in(w, 1'b1, sm, m, q);
        sb_q.push_back(ref_mul(w, sm, m, q));
        tick();
        set_in(w, 1'b0, sm, m, q);
        cyc = 0;
        while (get_done(w) !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== w + 1) begin n_fail++; $display("FAIL sweep_latency w=%0d: got %0d expected %0d", w, cyc, w + 1); end
        exp = sb_q.pop_front();
        n_checks++; if (get_prod(w) !== exp) begin
            n_fail++; $display("FAIL sweep_product w=%0d sm=%b m=%h q=%h: got %h expected %h", w, sm, m, q, get_prod(w), exp);
        end
    endtask

    task automatic test_width_sweep();
        for (int m = 0; m < 4; m++)
            for (int q = 0; q < 4; q++) begin
                sweep_op(2, 1'b1, 32'(m), 32'(q));
                sweep_op(2, 1'b0, 32'(m), 32'(q));
            end
        for (int m = 0; m < 16; m++)
            for (int q = 0; q < 16; q++)
                sweep_op(4, 1'b1, 32'(m), 32'(q));
        for (int i = 0; i < 16; i++)
            sweep_op(4, 1'b0, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
        sweep_op(16, 1'b1, 32'h8000, 32'h8000);
        sweep_op(16, 1'b0, 32'hFFFF, 32'hFFFF);
        sweep_op(16, 1'b1, 32'h8000, 32'h7FFF);
        for (int i = 0; i < 20; i++) begin
            sweep_op(16, 1'b1, $urandom, $urandom);
            sweep_op(16, 1'b0, $urandom, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_signed_corner();
        test_mixed_signs();
        test_unsigned_max();
        test_back_to_back();
        test_reset_mid_run();
        test_width_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
